// File: rtl/jk_seq_driver.sv
// jk_seq_driver: drives the J/K inputs of a bank of JK flip-flops through a
// stored table of target states. Each step drives the excitation for one
// clock, then checks on the next clock that the bank reached the target.
//
// Optional build macro: JKSEQ_LOOP_EN. When defined, the sequence wraps back
// to step 0 after the last step and keeps running until stop, a mismatch or
// s_reset. When undefined, the sequence runs once and then pulses done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, J/K held at 0
// ST_DRIVE | excitation for table[step_idx] on j_out/k_out for one clock
// ST_CHECK | J/K at 0 (bank holds), compare q_fb with table[step_idx]
// ST_DONE  | one-cycle done pulse, then back to idle
// ST_ERROR | mismatch seen, sticky until start or s_reset
module jk_seq_driver #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             s_reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [LW-1:0]    seq_len,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [AW-1:0]    err_idx,
   output logic [AW-1:0]    step_idx
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             error_q, error_d;
   logic [AW-1:0]    err_idx_q, err_idx_d;
   logic [AW-1:0]    step_idx_q, step_idx_d;
   logic [LW-1:0]    len_q, len_d;

   logic [WIDTH-1:0] tbl_q [DEPTH];

   logic [LW-1:0]    len_sel;
   logic             last_step;
   logic [WIDTH-1:0] tgt;
   logic             load_exc;
   logic [AW-1:0]    exc_idx;
   logic [WIDTH-1:0] exc_tgt;

   assign busy     = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
   assign done     = (state_q == ST_DONE);
   assign j_out    = j_q;
   assign k_out    = k_q;
   assign error    = error_q;
   assign err_idx  = err_idx_q;
   assign step_idx = step_idx_q;

   // Target table; writes are dropped while a sequence is in flight so the
   // running pass always sees a stable table.
   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         tbl_q[wr_addr] <= wr_data;
      end
   end

   assign len_sel   = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
   assign last_step = ({1'b0, step_idx_q} == (len_q - LW'(1)));
   assign tgt       = tbl_q[step_idx_q];
   assign exc_tgt   = tbl_q[exc_idx];

   // Next-state and registered-output logic. The excitation for a step is
   // computed on the edge that enters DRIVE, from q_fb as sampled on that edge.
   always_comb begin
      state_d    = state_q;
      j_d        = '0;
      k_d        = '0;
      error_d    = error_q;
      err_idx_d  = err_idx_q;
      step_idx_d = step_idx_q;
      len_d      = len_q;
      load_exc   = 1'b0;
      exc_idx    = step_idx_q;

      case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (start && !stop) begin
               len_d      = len_sel;
               error_d    = 1'b0;
               err_idx_d  = '0;
               step_idx_d = '0;
               if (len_sel == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_DRIVE;
                  load_exc = 1'b1;
                  exc_idx  = '0;
               end
            end
         end
         ST_DRIVE: begin
            state_d = stop ? ST_IDLE : ST_CHECK;
         end
         ST_CHECK: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (q_fb != tgt) begin
               error_d   = 1'b1;
               err_idx_d = step_idx_q;
               state_d   = ST_ERROR;
            end else if (last_step) begin
`ifdef JKSEQ_LOOP_EN
               step_idx_d = '0;
               state_d    = ST_DRIVE;
               load_exc   = 1'b1;
               exc_idx    = '0;
`else
               state_d = ST_DONE;
`endif
            end else begin
               step_idx_d = AW'(step_idx_q + 1'b1);
               state_d    = ST_DRIVE;
               load_exc   = 1'b1;
               exc_idx    = AW'(step_idx_q + 1'b1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Set only bits that must rise, clear only bits that must fall.
      if (load_exc) begin
         j_d = ~q_fb & exc_tgt;
         k_d = q_fb & ~exc_tgt;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (s_reset) begin
         state_q    <= ST_IDLE;
         j_q        <= '0;
         k_q        <= '0;
         error_q    <= 1'b0;
         err_idx_q  <= '0;
         step_idx_q <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         j_q        <= j_d;
         k_q        <= k_d;
         error_q    <= error_d;
         err_idx_q  <= err_idx_d;
         step_idx_q <= step_idx_d;
         len_q      <= len_d;
      end
   end

endmodule
